// File: rtl/inst_rom.sv
// Instruction ROM on the CPU fetch port: zero-latency word reads, contents loaded
// at run time through a byte-serial valid/ready port with big-endian word assembly.
module inst_rom #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rom_chip_enable,
    input  logic [31:0]           rom_addr,
    output logic [31:0]           rom_data,
    output logic                  addr_fault,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [7:0]            load_byte,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   loaded_words
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                state;
    logic [1:0]            bcnt;
    logic [23:0]           part;
    logic [ADDR_WIDTH:0]   wptr;
    logic [31:0]           mem [DEPTH];

    logic                  take;
    logic                  word_end;
    logic                  room;
    logic [31:0]           asm_word;

    // wptr never exceeds DEPTH, so its top bit alone marks a full array
    assign room     = !wptr[ADDR_WIDTH];
    assign take     = (state == LOAD) && load_valid && !load_start;
    assign word_end = take && (load_last || bcnt == 2'd3);

    // Bytes not yet received in a short final word read as zero
    always_comb begin
        asm_word = '0;
        case (bcnt)
            2'd0:    asm_word = {load_byte, 24'h0};
            2'd1:    asm_word = {part[23:16], load_byte, 16'h0};
            2'd2:    asm_word = {part[23:8], load_byte, 8'h0};
            default: asm_word = {part, load_byte};
        endcase
    end

    always_ff @(posedge clock) begin
        if (word_end && room)
            mem[wptr[ADDR_WIDTH-1:0]] <= asm_word;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            bcnt         <= '0;
            part         <= '0;
            wptr         <= '0;
            loaded_words <= '0;
            load_error   <= 1'b0;
            load_done    <= 1'b0;
            load_ready   <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            load_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state        <= LOAD;
                        load_ready   <= 1'b1;
                        bcnt         <= '0;
                        wptr         <= '0;
                        loaded_words <= '0;
                        load_error   <= 1'b0;
                    end
                end
                LOAD: begin
                    load_ready <= 1'b1;
                    if (load_start) begin
                        bcnt         <= '0;
                        wptr         <= '0;
                        loaded_words <= '0;
                        load_error   <= 1'b0;
                    end else if (load_valid) begin
                        case (bcnt)
                            2'd0:    part[23:16] <= load_byte;
                            2'd1:    part[15:8]  <= load_byte;
                            2'd2:    part[7:0]   <= load_byte;
                            default: ;
                        endcase
                        bcnt <= word_end ? 2'd0 : bcnt + 2'd1;
                        if (word_end) begin
                            if (room) wptr <= wptr + 1'b1;
                            else      load_error <= 1'b1;
                        end
                        if (load_last) begin
                            if (bcnt != 2'd3) load_error <= 1'b1;
                            loaded_words <= room ? wptr + 1'b1 : wptr;
                            state        <= DONE;
                            load_ready   <= 1'b0;
                            load_done    <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (load_start) begin
                        state        <= LOAD;
                        load_ready   <= 1'b1;
                        bcnt         <= '0;
                        wptr         <= '0;
                        loaded_words <= '0;
                        load_error   <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [ADDR_WIDTH-1:0] idx;
    logic                  hi_zero;
    logic                  in_img;

    assign idx     = rom_addr[ADDR_WIDTH+1:2];
    assign hi_zero = (rom_addr >> (ADDR_WIDTH + 2)) == 32'd0;
    assign in_img  = hi_zero && ({1'b0, idx} < loaded_words);

    // Reads are blanked during LOAD, so no read/write bypass is needed
    assign rom_data   = (rom_chip_enable && state != LOAD && in_img) ? mem[idx] : 32'h0;
    assign addr_fault = rom_chip_enable && ((rom_addr[1:0] != 2'b00) || !in_img);

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: a byte-list image model predicts every cycle's
// outputs, and a negedge monitor compares them against the DUT.
module tb_inst_rom;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ce = 1'b0;
    logic [31:0]   addr = '0;
    logic          load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic [7:0]    load_byte = '0;
    logic [31:0]   rom_data;
    logic          addr_fault, load_ready, load_done, load_error;
    logic [AW:0]   loaded_words;

    always #5 clock = ~clock;

    inst_rom #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .rom_chip_enable(ce), .rom_addr(addr),
        .rom_data(rom_data), .addr_fault(addr_fault),
        .load_start(load_start), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last),
        .load_ready(load_ready), .load_done(load_done),
        .load_error(load_error), .loaded_words(loaded_words)
    );

    typedef struct {
        logic [31:0] data;
        logic        fault, ready, done, err;
        logic [AW:0] words;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0, n_fail = 0;

    // Reference model: phase 0 idle, 1 loading, 2 done; image rebuilt from the byte list
    int          phase = 0;
    logic [7:0]  bq[$];
    logic [31:0] img[DEPTH];
    int          m_words = 0;
    bit          m_err = 0;

    function automatic exp_t expect_now();
        exp_t e;
        int   ix;
        bit   in_img;
        ix     = int'(addr[AW+1:2]);
        in_img = ((addr >> (AW + 2)) == 0) && (ix < m_words);
        e.data  = (ce && phase != 1 && in_img) ? img[ix] : 32'h0;
        e.fault = ce && (addr[1:0] != 2'b00 || !in_img);
        e.ready = (phase == 1);
        e.done  = (phase == 2);
        e.words = (AW+1)'(m_words);
        e.err   = (phase == 1) ? (bq.size() >= 4 * DEPTH + 4) : m_err;
        return e;
    endfunction

    task automatic finish_load();
        int sz, n, k;
        logic [31:0] w;
        sz = bq.size();
        n  = (sz + 3) / 4;
        k  = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < k; i++) begin
            w = '0;
            for (int j = 0; j < 4; j++)
                w = {w[23:0], (4 * i + j < sz) ? bq[4 * i + j] : 8'h00};
            img[i] = w;
        end
        m_words = k;
        m_err   = (sz % 4 != 0) || (n > DEPTH);
        phase   = 2;
    endtask

    task automatic model_edge();
        if (!reset) begin
            phase = 0; m_words = 0; m_err = 0; bq.delete();
        end else begin
            case (phase)
                0: if (load_start) begin phase = 1; bq.delete(); m_words = 0; m_err = 0; end
                1: if (load_start) bq.delete();
                   else if (load_valid) begin
                       bq.push_back(load_byte);
                       if (load_last) finish_load();
                   end
                default: if (load_start) begin phase = 1; bq.delete(); m_words = 0; m_err = 0; end
                         else phase = 0;
            endcase
        end
    endtask

    task automatic cyc(input bit r, input bit c, input logic [31:0] a,
                       input bit s, input bit v, input logic [7:0] d, input bit l);
        reset = r; ce = c; addr = a; load_start = s;
        load_valid = v; load_byte = d; load_last = l;
        q.push_back(expect_now());
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic fetch(input logic [31:0] a); cyc(1, 1, a, 0, 0, 8'h00, 0); endtask
    task automatic start(); cyc(1, 0, 32'h0, 1, 0, 8'h00, 0); endtask
    task automatic send(input logic [7:0] d, input bit l); cyc(1, 0, 32'h0, 0, 1, d, l); endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rom_data", rom_data, e.data);
            chk("addr_fault", 32'(addr_fault), 32'(e.fault));
            chk("load_ready", 32'(load_ready), 32'(e.ready));
            chk("load_done", 32'(load_done), 32'(e.done));
            chk("load_error", 32'(load_error), 32'(e.err));
            chk("loaded_words", 32'(loaded_words), 32'(e.words));
        end
    end

    initial begin
        logic [7:0] six[6];
        six = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        repeat (2) @(posedge clock);
        model_edge();
        #1;
        // reset state, then a 3-word image
        fetch(32'h0);
        fetch(32'h4);
        start();
        for (int i = 0; i < 12; i++) send(8'(i), i == 11);
        fetch(32'h4);
        fetch(32'h4);
        fetch(32'hC);
        fetch(32'h5);
        cyc(1, 0, 32'h4, 0, 0, 8'h00, 0);
        fetch(32'h8);
        fetch(32'h1000_0000);
        // partial final word
        start();
        for (int i = 0; i < 6; i++) send(six[i], i == 5);
        fetch(32'h4);
        fetch(32'h0);
        fetch(32'h8);
        // overflow with fetches and valid gaps during the load
        start();
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 1) fetch(32'h0);
            send(8'(8'h40 + i), i == 19);
        end
        for (int i = 0; i < 5; i++) fetch(32'(4 * i));
        // restart mid-load
        start();
        for (int i = 0; i < 5; i++) send(8'(8'h90 + i), 0);
        start();
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        fetch(32'h0);
        fetch(32'h4);
        // load_start straight out of DONE
        start();
        send(8'h01, 0); send(8'h02, 1);
        start();
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 0);
        send(8'hB1, 1);
        fetch(32'h0); fetch(32'h4);
        // reset mid-load, then bytes without load_start are ignored
        start();
        send(8'h55, 0); send(8'h66, 0);
        cyc(0, 0, 32'h0, 0, 1, 8'h77, 0);
        fetch(32'h0);
        fetch(32'h4);
        for (int i = 0; i < 6; i++) send(8'(8'hC0 + i), i == 5);
        fetch(32'h0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit r, c, s, v, l;
            logic [31:0] a;
            r = $urandom_range(0, 299) != 0;
            c = $urandom_range(0, 1) != 0;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4 * DEPTH + 7));
            s = $urandom_range(0, 39) == 0;
            v = $urandom_range(0, 9) < 7;
            l = v && ($urandom_range(0, 14) == 0);
            cyc(r, c, a, s, v, 8'($urandom), l);
        end
        repeat (2) @(negedge clock);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_rom.md
Name: inst_rom

Overview:
- Instruction-memory responder on the CPU fetch interface.
- Accepts the core's byte address and chip enable, and returns a 32-bit instruction word in the same cycle, so the fetch/decode buffer samples it on the next edge.
- Contents are filled at run time through a byte-serial load port with a valid/ready handshake. Words are assembled big-endian by a small load FSM.
- Sits beside the CPU top and drives its rom_data input.

Parameters:
- ADDR_WIDTH, 10, word-address width; DEPTH = 2**ADDR_WIDTH words.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- rom_chip_enable  in  1  fetch request from CPU
- rom_addr  in  32  byte address from CPU program counter
- rom_data  out  32  instruction word to CPU
- addr_fault  out  1  fetch address misaligned or outside loaded image
- load_start  in  1  pulse: begin a new image load
- load_valid  in  1  load_byte is valid
- load_byte  in  8  image byte, big-endian order
- load_last  in  1  qualifies the final byte of the image (valid only with load_valid)
- load_ready  out  1  block accepts a byte this cycle
- load_done  out  1  one-cycle pulse at the end of a load
- load_error  out  1  sticky: overflow or partial final word
- loaded_words  out  ADDR_WIDTH+1  number of valid words in the image

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE; byte count = 0; write pointer = 0.
  - loaded_words = 0; load_error = 0; load_done = 0; load_ready = 0.
  - The memory array is not cleared. Because loaded_words = 0, every fetch after reset returns 0.
  - Reset mid-load discards the load in progress.
- States: IDLE, LOAD, DONE.
- IDLE:
  - load_ready = 0; load_valid is ignored.
  - load_start moves to LOAD and clears the write pointer, byte count, loaded_words and load_error.
- LOAD:
  - load_ready = 1. A byte is accepted on an edge where load_valid=1.
  - Byte k of a word (k = 0..3) goes to bits [31-8k : 24-8k].
  - On the 4th byte, the word is written to mem[wptr], wptr increments and the byte count wraps to 0.
  - Overflow: a word completing when wptr == DEPTH is dropped and load_error is set. The block stays in LOAD until load_last.
  - load_last accepted with byte count k<3: the remaining bytes are zero-padded, the word is written (if there is room) and load_error is set.
  - On an accepted load_last, loaded_words = final wptr (saturates at DEPTH) and the state moves to DONE.
  - load_start in LOAD restarts the load: the partial word is discarded, wptr/count/loaded_words/load_error are cleared, and the state stays in LOAD. load_start has priority over a simultaneous byte.
- DONE:
  - load_done = 1 and load_ready = 0 for exactly one cycle, then IDLE.
  - load_start in DONE goes directly to LOAD; load_done still pulses that cycle.
- Read path (combinational, zero latency):
  - idx = rom_addr[ADDR_WIDTH+1:2].
  - rom_data = mem[idx] when rom_chip_enable=1, state != LOAD, and idx < loaded_words. Otherwise rom_data = 0 (NOP).
  - Address bits above ADDR_WIDTH+1 that are nonzero count as outside the image.
  - addr_fault = rom_chip_enable && (rom_addr[1:0] != 0 || out of image).
  - A misaligned address still returns the word at idx.
- A write and a read of the same index in one cycle cannot conflict, because reads are suppressed during LOAD.
- Expected implementation size: 120-400 lines of RTL.

Test Plan:
- Reset, then load_start and 12 bytes 00..0B with last on 0B → load_done pulse; loaded_words=3, load_error=0. Fetch addr 0x4 with ce=1 → rom_data=0x04050607, addr_fault=0.
- Fetch addr 0xC after the above → rom_data=0, addr_fault=1. Fetch addr 0x5 → rom_data=0x04050607, addr_fault=1. ce=0 → rom_data=0, addr_fault=0.
- Load 6 bytes AA,BB,CC,DD,EE,FF with last on FF → loaded_words=2, load_error=1. Word 1 reads 0xEEFF0000.
- ADDR_WIDTH=2: load 20 bytes → loaded_words=4, load_error=1, word 3 intact. A fetch during load with load_valid gaps → rom_data=0.
- load_start after 5 bytes, then 4 bytes 11,22,33,44 with last → loaded_words=1, word 0 = 0x11223344, load_error=0.
- Assert reset=0 for one cycle mid-load → load_ready=0, loaded_words=0, all fetches return 0. A subsequent load_valid is ignored until load_start.
